// File: rtl/vec_exec_pkg.sv
// Shared types and constants for the vector execution dispatch stage.
package vec_exec_pkg;

    // Dispatch sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC_ALU  = 3'd1,
        ST_MUL_START = 3'd2,
        ST_MUL_WAIT  = 3'd3,
        ST_WB        = 3'd4
    } exec_state_e;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SEW_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_MUL = 3'b011;

    localparam logic [SEW_W-1:0] SEW_E8  = 6'b001000;
    localparam logic [SEW_W-1:0] SEW_E16 = 6'b010000;
    localparam logic [SEW_W-1:0] SEW_E32 = 6'b100000;

    // Control fields latched with an accepted op and replayed to the execution unit.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             ctrl;
        logic             sign_mode;
        logic [SEW_W-1:0] sew;
    } exec_ctrl_t;

    // True only for the three supported one-hot element widths.
    function automatic logic sew_legal(input logic [SEW_W-1:0] sew);
        return (sew == SEW_E8) || (sew == SEW_E16) || (sew == SEW_E32);
    endfunction

endpackage

// File: rtl/vec_exec_dispatch.sv
// Issue/sequencing stage in front of the vector execution unit: accepts one op,
// drives the unit, waits for the result and hands it to writeback.
module vec_exec_dispatch
    import vec_exec_pkg::*;
#(
    parameter int unsigned VLEN        = 512,
    parameter int unsigned VD_W        = 5,
    parameter int unsigned MUL_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VLEN-1:0]  in_data_1,
    input  logic [VLEN-1:0]  in_data_2,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_ctrl,
    input  logic             in_signed,
    input  logic [SEW_W-1:0] in_sew_eew,
    input  logic [VD_W-1:0]  in_vd,
    output logic [VLEN-1:0]  ex_data_1,
    output logic [VLEN-1:0]  ex_data_2,
    output logic             ex_ctrl,
    output logic             ex_signed,
    output logic [SEW_W-1:0] ex_sew_eew,
    output logic [OP_W-1:0]  ex_op,
    output logic             ex_start,
    input  logic             ex_done,
    input  logic [VLEN-1:0]  ex_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [VD_W-1:0]  wb_vd,
    output logic [VLEN-1:0]  wb_data,
    output logic             wb_err,
    output logic             busy
);

    localparam int unsigned      WD_W    = $clog2(MUL_TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MUL_TIMEOUT - 1);

    exec_state_e       state;
    exec_ctrl_t        ctrl_q;
    logic [VLEN-1:0]   data1_q;
    logic [VLEN-1:0]   data2_q;
    logic [VD_W-1:0]   vd_q;
    logic [WD_W-1:0]   wd_q;

    // Operand registers feed the execution unit directly; they only change on accept.
    assign ex_data_1  = data1_q;
    assign ex_data_2  = data2_q;
    assign ex_ctrl    = ctrl_q.ctrl;
    assign ex_signed  = ctrl_q.sign_mode;
    assign ex_sew_eew = ctrl_q.sew;
    assign ex_op      = ctrl_q.op;
    assign wb_vd      = vd_q;

    // Handshake status decoded straight from the state.
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // Sequencing FSM with operand capture, start pulse, watchdog and writeback hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ctrl_q   <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            vd_q     <= '0;
            wd_q     <= '0;
            ex_start <= 1'b0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_err   <= 1'b0;
        end else begin
            ex_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data1_q          <= in_data_1;
                        data2_q          <= in_data_2;
                        vd_q             <= in_vd;
                        ctrl_q.op        <= in_op;
                        ctrl_q.ctrl      <= in_ctrl;
                        ctrl_q.sign_mode <= in_signed;
                        ctrl_q.sew       <= in_sew_eew;
                        if (!sew_legal(in_sew_eew) ||
                            ((in_op != OP_ADD) && (in_op != OP_MUL))) begin
                            // Illegal op: report the error without touching the unit.
                            state    <= ST_WB;
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_data  <= '0;
                        end else if (in_op == OP_ADD) begin
                            state <= ST_EXEC_ALU;
                        end else begin
                            state    <= ST_MUL_START;
                            ex_start <= 1'b1;
                        end
                    end
                end
                ST_EXEC_ALU: begin
                    state    <= ST_WB;
                    wb_valid <= 1'b1;
                    wb_err   <= 1'b0;
                    wb_data  <= ex_result;
                end
                ST_MUL_START: begin
                    state <= ST_MUL_WAIT;
                    wd_q  <= '0;
                end
                ST_MUL_WAIT: begin
                    if (ex_done) begin
                        state    <= ST_WB;
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b0;
                        wb_data  <= ex_result;
                    end else if (wd_q == WD_LAST) begin
                        state    <= ST_WB;
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_data  <= '0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        state    <= ST_IDLE;
                        wb_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
